stage_if_fetch_unit: RTL and testbench

Instruction-fetch stage that drives the IF/ID pipeline register. It owns the program counter and issues one request at a time to a variable-latency instruction memory using a req/ready + rvalid handshake. It presents {pc+step, instruction, valid} downstream and honours freeze and branch redirection. When no instruction is available it outputs a zero instruction, which acts as a bubble.

---
 rtl/stage_if_fetch_unit.sv | 193 +++++++++++++++++++
 tb/tb_stage_if_fetch_unit.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_if_fetch_unit.sv
//==============================================================================
// Module   : stage_if_fetch_unit
// Purpose  : Instruction-fetch stage that drives the IF/ID pipeline register.
//            It owns the program counter and keeps at most one request in
//            flight to a variable-latency instruction memory using a
//            req/ready + rvalid handshake. A fetched instruction is presented
//            as {pc_out = fetch address + PC_STEP, instruction_out, if_valid}.
//            It is held while freeze is high and is dropped on a branch
//            redirect. When nothing is available, instruction_out is 0, which
//            acts as a bubble.
// Optional : `IF_STALL_COUNT_EN adds stall_cycles, a saturating count of the
//            clock edges where if_valid was 0.
//
// Ports    : clk             rising-edge clock
//            rst             asynchronous reset, active low
//            freeze          downstream stall; hold the buffered instruction
//            branch_taken    redirect request; takes priority over freeze
//            branch_addr     redirect target
//            imem_req        fetch request valid
//            imem_addr       fetch address (current pc)
//            imem_ready      memory accepts the request this cycle
//            imem_rvalid     read data valid
//            imem_rdata      read data
//            pc_out          fetched address + PC_STEP
//            instruction_out fetched instruction, 0 when not valid
//            if_valid        pc_out/instruction_out hold a real instruction
//            if_stall        ~if_valid
//            stall_cycles    (optional) saturating stall counter
//
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module stage_if_fetch_unit #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       PC_STEP  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_addr,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  output logic [ADDR_W-1:0] pc_out,
  output logic [31:0]       instruction_out,
  output logic              if_valid,
`ifdef IF_STALL_COUNT_EN
  output logic [31:0]       stall_cycles,
`endif
  output logic              if_stall
);

  localparam logic [ADDR_W-1:0] C_PC_STEP = ADDR_W'(PC_STEP);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   req_pc_q, req_pc_d;
  logic                drop_q, drop_d;
  logic [ADDR_W-1:0]   pc_out_q, pc_out_d;
  logic [31:0]         instr_q, instr_d;
  logic                valid_q, valid_d;

  // Next-state logic. Addition wraps modulo 2^ADDR_W by construction.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    drop_d   = drop_q;
    pc_out_d = pc_out_q;
    instr_d  = instr_q;
    valid_d  = valid_q;

    unique case (state_q)
      S_FETCH: begin
        // Any rvalid seen here belongs to a request that no longer matters
        // (e.g. one issued before a reset), so it is ignored.
        if (branch_taken) begin
          pc_d = branch_addr;
        end else if (imem_ready) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + C_PC_STEP;
          state_d  = S_WAIT;
        end
      end

      S_WAIT: begin
        if (imem_rvalid) begin
          if (drop_q || branch_taken) begin
            // Response belongs to a path that has been redirected away from.
            drop_d  = 1'b0;
            state_d = S_FETCH;
            if (branch_taken) begin
              pc_d = branch_addr;
            end
          end else begin
            pc_out_d = req_pc_q + C_PC_STEP;
            instr_d  = imem_rdata;
            valid_d  = 1'b1;
            state_d  = S_HOLD;
          end
        end else if (branch_taken) begin
          // Cannot cancel the outstanding request; remember to discard it.
          pc_d   = branch_addr;
          drop_d = 1'b1;
        end
      end

      S_HOLD: begin
        if (branch_taken) begin
          pc_d     = branch_addr;
          pc_out_d = '0;
          instr_d  = '0;
          valid_d  = 1'b0;
          state_d  = S_FETCH;
        end else if (!freeze) begin
          // IF/ID captures the instruction at this edge.
          pc_out_d = '0;
          instr_d  = '0;
          valid_d  = 1'b0;
          state_d  = S_FETCH;
        end
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
      drop_q   <= 1'b0;
      pc_out_q <= '0;
      instr_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      drop_q   <= drop_d;
      pc_out_q <= pc_out_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
    end
  end

  // The request is withheld in the cycle a redirect arrives so the stale pc
  // is never fetched.
  assign imem_req        = (state_q == S_FETCH) && !branch_taken;
  assign imem_addr       = pc_q;
  assign pc_out          = pc_out_q;
  assign instruction_out = instr_q;
  assign if_valid        = valid_q;
  assign if_stall        = ~valid_q;

`ifdef IF_STALL_COUNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!valid_q && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_stage_if_fetch_unit.sv
//==============================================================================
// Module   : tb_stage_if_fetch_unit
// Purpose  : Directed self-checking bench for stage_if_fetch_unit with a
//            behavioural variable-latency instruction memory
//            (rdata = addr ^ 32'hA5A5_A5A5).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_stage_if_fetch_unit;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] pc_out;
  logic [31:0] instruction_out;
  logic        if_valid;
  logic        if_stall;
`ifdef IF_STALL_COUNT_EN
  logic [31:0] stall_cycles;
`endif

  stage_if_fetch_unit #(
    .ADDR_W   (32),
    .RESET_PC (32'h0000_0000),
    .PC_STEP  (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .freeze          (freeze),
    .branch_taken    (branch_taken),
    .branch_addr     (branch_addr),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ready      (imem_ready),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .pc_out          (pc_out),
    .instruction_out (instruction_out),
    .if_valid        (if_valid),
`ifdef IF_STALL_COUNT_EN
    .stall_cycles    (stall_cycles),
`endif
    .if_stall        (if_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;

  // Memory model / bookkeeping state
  int          lat      = 1;
  int          lat_cnt  = 0;
  logic        pend     = 1'b0;
  logic [31:0] pend_addr = '0;
  logic [31:0] last_acc = '0;
  int          n_acc    = 0;
  logic [31:0] exp_stall = '0;
  int          acc_before;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle. Entered and left at a falling edge; stimulus is set by
  // the caller just before, outputs are checked by the caller just after.
  task automatic step();
    logic acc;
    logic [31:0] acc_a;
    logic v;
    if (pend) begin
      if (lat_cnt <= 1) begin
        imem_rvalid = 1'b1;
        imem_rdata  = pend_addr ^ 32'hA5A5_A5A5;
        pend        = 1'b0;
      end else begin
        lat_cnt--;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
      end
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
    #1;
    acc   = imem_req && imem_ready && rst;
    acc_a = imem_addr;
    v     = if_valid;
    @(posedge clk);
    if (acc) begin
      pend      = 1'b1;
      lat_cnt   = lat;
      pend_addr = acc_a;
      last_acc  = acc_a;
      n_acc++;
    end
    if (!rst) exp_stall = '0;
    else if (!v && exp_stall != 32'hFFFF_FFFF) exp_stall++;
    @(negedge clk);
  endtask

  initial begin
    rst          = 1'b0;
    freeze       = 1'b0;
    branch_taken = 1'b0;
    branch_addr  = '0;
    imem_ready   = 1'b1;
    imem_rvalid  = 1'b0;
    imem_rdata   = '0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_valid", {31'd0, if_valid}, 32'd0);
    check("rst_stall", {31'd0, if_stall}, 32'd1);
    check("rst_pc_out", pc_out, 32'h0);
    check("rst_instr", instruction_out, 32'h0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_req", {31'd0, imem_req}, 32'd1);
`ifdef IF_STALL_COUNT_EN
    check("rst_stall_cnt", stall_cycles, 32'h0);
`endif
    rst = 1'b1;

    // Test 1: basic fetch sequence 0, 4, 8
    step(); step();
    check("t1_acc0", last_acc, 32'h0);
    check("t1_valid0", {31'd0, if_valid}, 32'd1);
    check("t1_pc0", pc_out, 32'h4);
    check("t1_ins0", instruction_out, 32'hA5A5_A5A5);
    check("t1_req_hold", {31'd0, imem_req}, 32'd0);
    step();
    check("t1_consumed", {31'd0, if_valid}, 32'd0);
    check("t1_bubble", instruction_out, 32'h0);
    check("t1_addr4", imem_addr, 32'h4);
    step(); step();
    check("t1_acc4", last_acc, 32'h4);
    check("t1_pc1", pc_out, 32'h8);
    check("t1_ins1", instruction_out, 32'hA5A5_A5A1);
    step(); step(); step();
    check("t1_acc8", last_acc, 32'h8);
    check("t1_pc2", pc_out, 32'hC);
    check("t1_ins2", instruction_out, 32'hA5A5_A5AD);

    // Test 2: freeze holds the instruction for 5 cycles
    freeze = 1'b1;
    acc_before = n_acc;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t2_valid", {31'd0, if_valid}, 32'd1);
      check("t2_pc", pc_out, 32'hC);
      check("t2_req", {31'd0, imem_req}, 32'd0);
    end
    check("t2_no_acc", n_acc, acc_before);
    freeze = 1'b0;
    step();
    check("t2_released", {31'd0, if_valid}, 32'd0);
    check("t2_addrC", imem_addr, 32'hC);
    step();
    check("t2_accC", last_acc, 32'hC);
    step();
    check("t2_pcC", pc_out, 32'h10);
    step();

    // Test 3: branch during WAIT, response 3 cycles later is discarded
    lat = 3;
    step();
    check("t3_acc10", last_acc, 32'h10);
    branch_taken = 1'b1;
    branch_addr  = 32'h100;
    step();
    branch_taken = 1'b0;
    check("t3_addr_redirect", imem_addr, 32'h100);
    step(); step();
    check("t3_discard", {31'd0, if_valid}, 32'd0);
    check("t3_req", {31'd0, imem_req}, 32'd1);
    check("t3_addr100", imem_addr, 32'h100);
    lat = 1;
    step(); step();
    check("t3_acc100", last_acc, 32'h100);
    check("t3_pc", pc_out, 32'h104);
    check("t3_ins", instruction_out, 32'hA5A5_A4A5);

    // Test 4: branch and freeze together in HOLD - branch wins
    freeze       = 1'b1;
    branch_taken = 1'b1;
    branch_addr  = 32'h200;
    step();
    check("t4_valid", {31'd0, if_valid}, 32'd0);
    check("t4_pc_out", pc_out, 32'h0);
    check("t4_addr", imem_addr, 32'h200);
    freeze       = 1'b0;
    branch_taken = 1'b0;

    // Test 5: reset during WAIT, stale rvalid after release is ignored
    lat = 3;
    step();
    check("t5_acc200", last_acc, 32'h200);
    step();
    rst = 1'b0;
    #1;
    check("t5_rst_addr", imem_addr, 32'h0);
    check("t5_rst_valid", {31'd0, if_valid}, 32'd0);
    lat = 1;
    step();
    rst = 1'b1;
    step();
    check("t5_stale_ignored", {31'd0, if_valid}, 32'd0);
    check("t5_acc0", last_acc, 32'h0);
    check("t5_addr4", imem_addr, 32'h4);
    step();
    check("t5_pc", pc_out, 32'h4);
    check("t5_ins", instruction_out, 32'hA5A5_A5A5);

    // Test 6: wrap at top of address space, with ready held low first
    branch_taken = 1'b1;
    branch_addr  = 32'hFFFF_FFFC;
    step();
    branch_taken = 1'b0;
    imem_ready   = 1'b0;
    acc_before   = n_acc;
    step(); step();
    check("t6_req_wait", {31'd0, imem_req}, 32'd1);
    check("t6_addr_top", imem_addr, 32'hFFFF_FFFC);
    check("t6_no_acc", n_acc, acc_before);
    imem_ready = 1'b1;
    step();
    check("t6_acc_top", last_acc, 32'hFFFF_FFFC);
    check("t6_addr_wrap", imem_addr, 32'h0);
    step();
    check("t6_valid", {31'd0, if_valid}, 32'd1);
    check("t6_pc_wrap", pc_out, 32'h0);
    check("t6_ins", instruction_out, 32'h5A5A_5A59);
`ifdef IF_STALL_COUNT_EN
    check("t6_stall_cnt", stall_cycles, exp_stall);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
